fpumul_retire: RTL and testbench

FPUMUL_RETIRE -- requirements
Module: fpumul_retire

---
 rtl/fpumul_retire_pkg.sv | 51 +++++
 rtl/fpu_retire_fifo.sv | 59 +++++
 rtl/fpumul_retire.sv | 103 ++++++++++
 tb/tb_fpumul_retire.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fpumul_retire_pkg.sv
// Shared FPU retire definitions: exception-flag bit positions, result
// type encodings and the packed layout of one retire buffer entry.
package fpumul_retire_pkg;

  // Exception raise/enable vector bit positions (csrfpu_* layout)
  localparam int CSRFPU_W     = 11;
  localparam int CSRFPU_NX    = 0;   // inexact
  localparam int CSRFPU_UF    = 1;   // underflow
  localparam int CSRFPU_OF    = 2;   // overflow
  localparam int CSRFPU_DZ    = 3;   // divide by zero
  localparam int CSRFPU_NV    = 4;   // invalid operation
  localparam int CSRFPU_DN    = 5;   // denormal operand
  localparam int CSRFPU_SNAN  = 6;   // signalling NaN operand
  localparam int CSRFPU_QNAN  = 7;   // quiet NaN operand
  localparam int CSRFPU_INF   = 8;   // infinite operand
  localparam int CSRFPU_STK   = 9;   // stack fault
  localparam int CSRFPU_ES    = 10;  // error summary

  // Result bus layout
  localparam int RES_W        = 68;
  localparam int RES_HI_W     = 16;
  localparam int TAG_W        = 9;
  localparam int PTYPE_MSB    = 67;
  localparam int PTYPE_LSB    = 66;
  localparam int SIGN_BIT     = 65;

  // Result type carried in res[67:66]; retire logic never decodes it
  typedef enum logic [1:0] {
    PT_SINGLE  = 2'b00,
    PT_DOUBLE  = 2'b01,
    PT_EXT     = 2'b10,
    PT_SPECIAL = 2'b11
  } ptype_e;

  // One buffered multiplier result: 68 + 16 + 11 + 9 bits
  localparam int ENTRY_W = RES_W + RES_HI_W + CSRFPU_W + TAG_W;

  typedef struct packed {
    logic [RES_W-1:0]    res;
    logic [RES_HI_W-1:0] res_hi;
    logic [CSRFPU_W-1:0] raise;
    logic [TAG_W-1:0]    tag;
  } entry_t;

  // True when any raised exception is enabled in the mask
  function automatic logic excpt_hit(input logic [CSRFPU_W-1:0] raise,
                                     input logic [CSRFPU_W-1:0] mask);
    return |(raise & mask);
  endfunction

endpackage

// File: rtl/fpu_retire_fifo.sv
// Retire buffer storage: single write port, single read port, wrapping
// pointers and an occupancy count. The caller never pushes into a full
// buffer without a matching pop and never pops an empty one.
module fpu_retire_fifo #(
  parameter int WIDTH = 104,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic [$clog2(DEPTH):0]     count_next
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Head entry is visible without waiting for a read strobe
  assign rd_data = mem[rd_ptr];

  // Occupancy after this edge; simultaneous push and pop cancel out
  always_comb begin
    count_next = count;
    count_next = count + (AW+1)'(push) - (AW+1)'(pop);
  end

  // Pointer and count update; pointers wrap modulo DEPTH by width
`ifdef swapedge
  always_ff @(posedge clk or negedge rst) begin
`else
  always_ff @(negedge clk or negedge rst) begin
`endif
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
    end
  end

  // Entry storage carries no reset; contents are meaningless when empty
`ifdef swapedge
  always_ff @(posedge clk) begin
`else
  always_ff @(negedge clk) begin
`endif
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/fpumul_retire.sv
// Multiplier retire stage: buffers multiplier results in order, hands the
// head to writeback, accumulates sticky exception flags in retire order and
// tells issue to hold off when the buffer cannot absorb in-flight results.
module fpumul_retire
  import fpumul_retire_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int STALL_THR = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mul_vld,
  input  logic [67:0]   mul_res,
  input  logic [15:0]   mul_res_hi,
  input  logic [10:0]   mul_raise,
  input  logic [8:0]    mul_tag,
  input  logic [10:0]   excpt_mask,
  input  logic          clr_flags,
  input  logic          wb_rdy,
  output logic          wb_vld,
  output logic [67:0]   wb_res,
  output logic [15:0]   wb_res_hi,
  output logic [8:0]    wb_tag,
  output logic          wb_excpt,
  output logic [10:0]   flags,
  output logic          stall,
  output logic          drop_err
);

  localparam int AW = $clog2(DEPTH);

  entry_t       wr_entry;
  entry_t       head;
  logic [AW:0]  count;
  logic [AW:0]  count_next;
  logic [AW:0]  free_next;
  logic         full;
  logic         push;
  logic         pop;
  logic         drop;
  logic         armed;
  logic         stall_next;

  assign wr_entry = '{res: mul_res, res_hi: mul_res_hi,
                      raise: mul_raise, tag: mul_tag};

  fpu_retire_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (pop),
    .wr_data    (wr_entry),
    .rd_data    (head),
    .count      (count),
    .count_next (count_next)
  );

  // A full buffer still accepts a result when the head retires on the same
  // edge; otherwise the result is lost and reported through drop_err.
  // Nothing is accepted until one edge has passed since reset release.
  assign full   = (count == (AW+1)'(DEPTH));
  assign wb_vld = (count != '0);
  assign pop    = wb_vld & wb_rdy;
  assign push   = mul_vld & armed & (~full | pop);
  assign drop   = mul_vld & armed & full & ~pop;

  // Result fields pass straight through, ptype included
  assign wb_res    = head.res;
  assign wb_res_hi = head.res_hi;
  assign wb_tag    = head.tag;
  assign wb_excpt  = wb_vld & excpt_hit(head.raise, excpt_mask);

  // Stall looks at the occupancy being loaded this edge so it tracks count
  assign free_next  = (AW+1)'(DEPTH) - count_next;
  assign stall_next = (32'(free_next) <= STALL_THR);

  // Sticky flags, drop tracking, stall register and reset-release arming
`ifdef swapedge
  always_ff @(posedge clk or negedge rst) begin
`else
  always_ff @(negedge clk or negedge rst) begin
`endif
    if (!rst) begin
      armed    <= 1'b0;
      flags    <= '0;
      drop_err <= 1'b0;
      stall    <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (pop)
        flags <= (clr_flags ? '0 : flags) | head.raise;
      else if (clr_flags)
        flags <= '0;
      if (drop)
        drop_err <= 1'b1;
      stall <= stall_next;
    end
  end

endmodule

// File: tb/tb_fpumul_retire.sv
// Directed bench for fpumul_retire: stimulus pushes the expected retire
// stream into a queue and an independent monitor checks each writeback.
module tb_fpumul_retire;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mul_vld = 1'b0;
  logic [67:0] mul_res = '0;
  logic [15:0] mul_res_hi = '0;
  logic [10:0] mul_raise = '0;
  logic [8:0]  mul_tag = '0;
  logic [10:0] excpt_mask = '0;
  logic        clr_flags = 1'b0;
  logic        wb_rdy = 1'b0;
  logic        wb_vld;
  logic [67:0] wb_res;
  logic [15:0] wb_res_hi;
  logic [8:0]  wb_tag;
  logic        wb_excpt;
  logic [10:0] flags;
  logic        stall;
  logic        drop_err;

  typedef struct {
    logic [8:0]  tag;
    logic [67:0] res;
    logic [15:0] res_hi;
    logic [10:0] raise;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  fpumul_retire #(.DEPTH(4), .STALL_THR(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .mul_vld    (mul_vld),
    .mul_res    (mul_res),
    .mul_res_hi (mul_res_hi),
    .mul_raise  (mul_raise),
    .mul_tag    (mul_tag),
    .excpt_mask (excpt_mask),
    .clr_flags  (clr_flags),
    .wb_rdy     (wb_rdy),
    .wb_vld     (wb_vld),
    .wb_res     (wb_res),
    .wb_res_hi  (wb_res_hi),
    .wb_tag     (wb_tag),
    .wb_excpt   (wb_excpt),
    .flags      (flags),
    .stall      (stall),
    .drop_err   (drop_err)
  );

  always #5 clk = ~clk;

  task automatic wait_active();
`ifdef swapedge
    @(posedge clk);
`else
    @(negedge clk);
`endif
  endtask

  task automatic wait_opposite();
`ifdef swapedge
    @(negedge clk);
`else
    @(posedge clk);
`endif
  endtask

  function automatic logic [67:0] mk_res(input logic [8:0] t);
    return {t[1:0], 1'b1, 56'hC0FFEE12345678, t};
  endfunction

  function automatic logic [15:0] mk_hi(input logic [8:0] t);
    return {7'h2A, t};
  endfunction

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // One active edge of stimulus; queue model predicts acceptance
  task automatic step(input logic v, input logic [8:0] tag,
                      input logic [10:0] raise, input logic rdy,
                      input logic clr);
    exp_t e;
    logic do_pop;
    logic do_push;
    mul_vld    = v;
    mul_tag    = tag;
    mul_raise  = raise;
    mul_res    = mk_res(tag);
    mul_res_hi = mk_hi(tag);
    wb_rdy     = rdy;
    clr_flags  = clr;
    do_pop  = (q.size() > 0) && rdy;
    do_push = v && ((q.size() < 4) || do_pop);
    if (do_push) begin
      e.tag = tag; e.res = mk_res(tag); e.res_hi = mk_hi(tag); e.raise = raise;
      q.push_back(e);
    end
    wait_active();
    #1;
    mul_vld   = 1'b0;
    wb_rdy    = 1'b0;
    clr_flags = 1'b0;
  endtask

  // Monitor: every writeback handshake must match the oldest expectation
  initial begin
    exp_t e;
    forever begin
      wait_opposite();
      if (rst && wb_vld && wb_rdy) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wb_unexpected got tag %0h expected none", wb_tag);
        end else begin
          e = q.pop_front();
          chk("wb_tag", wb_tag, e.tag);
          chk("wb_res", wb_res, e.res);
          chk("wb_res_hi", wb_res_hi, e.res_hi);
          chk("wb_excpt", wb_excpt, |(e.raise & excpt_mask));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b0;
    wait_active(); #1;
    chk("rst_wb_vld", wb_vld, 0);
    chk("rst_stall", stall, 0);
    chk("rst_flags", flags, 0);
    chk("rst_drop_err", drop_err, 0);
    chk("rst_wb_excpt", wb_excpt, 0);
    wait_active(); #1;
    rst = 1'b1;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // Single result, one-edge latency, flags on retire
    step(1, 9'h05, 11'h010, 0, 0);
    chk("lat_wb_vld", wb_vld, 1);
    chk("lat_wb_tag", wb_tag, 9'h05);
    chk("lat_stall", stall, 0);
    step(0, 0, 0, 1, 0);
    chk("retire_flags", flags, 11'h010);
    chk("retire_empty", wb_vld, 0);
    step(0, 0, 0, 0, 1);
    chk("clr_flags_idle", flags, 0);

    // Fill to full, stall threshold, drop of a fifth result
    step(1, 9'h01, 0, 0, 0);
    chk("fill1_stall", stall, 0);
    step(1, 9'h02, 0, 0, 0);
    chk("fill2_stall", stall, 1);
    step(1, 9'h03, 0, 0, 0);
    step(1, 9'h04, 0, 0, 0);
    chk("full_no_drop", drop_err, 0);
    step(1, 9'h09, 0, 0, 0);
    chk("drop_set", drop_err, 1);
    chk("drop_stall", stall, 1);
    chk("drop_head_hold", wb_tag, 9'h01);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);
    chk("drain_empty", wb_vld, 0);
    chk("drain_stall", stall, 0);
    chk("drop_sticky", drop_err, 1);

    // Asynchronous reset mid-stream with three entries held
    step(1, 9'h11, 0, 0, 0);
    step(1, 9'h12, 0, 0, 0);
    step(1, 9'h13, 0, 0, 0);
    chk("three_stall", stall, 1);
    chk("three_vld", wb_vld, 1);
    #2 rst = 1'b0;
    #1;
    chk("async_wb_vld", wb_vld, 0);
    chk("async_stall", stall, 0);
    chk("async_drop_err", drop_err, 0);
    q.delete();
    wait_active(); #1;
    rst = 1'b1;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 9'h20, 0, 0, 0);
    chk("post_rst_vld", wb_vld, 1);
    chk("post_rst_tag", wb_tag, 9'h20);
    chk("post_rst_stall", stall, 0);

    // Full buffer with enqueue and dequeue on the same edge
    step(1, 9'h21, 0, 0, 0);
    step(1, 9'h22, 0, 0, 0);
    step(1, 9'h23, 0, 0, 0);
    chk("full2_stall", stall, 1);
    step(1, 9'h24, 0, 1, 0);
    chk("simul_no_drop", drop_err, 0);
    chk("simul_stall", stall, 1);
    chk("simul_head", wb_tag, 9'h21);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
    chk("simul_new_head", wb_tag, 9'h24);
    chk("simul_new_vld", wb_vld, 1);
    step(0, 0, 0, 1, 0);
    chk("simul_drained", wb_vld, 0);

    // Flag accumulation and clear ordering
    step(1, 9'h30, 11'h001, 0, 0);
    step(1, 9'h31, 11'h002, 0, 0);
    step(1, 9'h32, 11'h100, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    chk("flags_acc", flags, 11'h003);
    step(0, 0, 0, 1, 1);
    chk("flags_clr_deq", flags, 11'h100);
    step(0, 0, 0, 0, 1);
    chk("flags_clr_only", flags, 0);

    // Exception enable masking on the head entry
    excpt_mask = 11'h001;
    step(1, 9'h40, 11'h001, 0, 0);
    step(1, 9'h41, 11'h002, 0, 0);
    chk("excpt_hit", wb_excpt, 1);
    step(0, 0, 0, 1, 0);
    chk("excpt_miss", wb_excpt, 0);
    chk("excpt_miss_tag", wb_tag, 9'h41);
    step(0, 0, 0, 1, 0);
    chk("excpt_empty", wb_excpt, 0);

    step(0, 0, 0, 0, 0);
    chk("scoreboard_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
